// File: rtl/display_scan.sv
// Six-digit multiplexed seven-segment scanner with a double-buffered digit bank; frame-aligned bank swap.
// Outputs registered, 1-cycle latency; no backpressure; optional LEADING_ZERO_BLANK_EN blanks leading zeros.
module display_scan #(
  parameter int CLKS_PER_DIGIT = 50000
) (
  input  logic       clk,
  input  logic       reset,
  input  logic       load,
  input  logic [3:0] d1,
  input  logic [3:0] d2,
  input  logic [3:0] d3,
  input  logic [3:0] d4,
  input  logic [3:0] d5,
  input  logic [3:0] d6,
  output logic [6:0] seg,
  output logic [5:0] an,
  output logic       frame_done,
  output logic       pending
);

  localparam logic [15:0] DIV_LAST = 16'(CLKS_PER_DIGIT - 1);

  logic [15:0]     div;
  logic [2:0]      idx;
  logic [5:0][3:0] active;
  logic [5:0][3:0] shadow;
  logic [5:0][3:0] din;
  logic            tick;
  logic            boundary;
  logic [3:0]      cur_digit;
  logic [5:0]      an_nxt;
  logic            cur_blank;

  assign din      = {d6, d5, d4, d3, d2, d1};
  assign tick     = (div == DIV_LAST);
  assign boundary = tick && (idx == 3'd5);

  function automatic logic [6:0] hex7(input logic [3:0] v);
    case (v)
      4'h0:    hex7 = 7'h40;
      4'h1:    hex7 = 7'h79;
      4'h2:    hex7 = 7'h24;
      4'h3:    hex7 = 7'h30;
      4'h4:    hex7 = 7'h19;
      4'h5:    hex7 = 7'h12;
      4'h6:    hex7 = 7'h02;
      4'h7:    hex7 = 7'h78;
      4'h8:    hex7 = 7'h00;
      4'h9:    hex7 = 7'h10;
      4'hA:    hex7 = 7'h08;
      4'hB:    hex7 = 7'h03;
      4'hC:    hex7 = 7'h46;
      4'hD:    hex7 = 7'h21;
      4'hE:    hex7 = 7'h06;
      default: hex7 = 7'h0E;
    endcase
  endfunction

  // idx never reaches 6 or 7; those fall back to digit 0 so an stays one-hot.
  always_comb begin
    cur_digit = active[0];
    an_nxt    = 6'b111110;
    case (idx)
      3'd1: begin cur_digit = active[1]; an_nxt = 6'b111101; end
      3'd2: begin cur_digit = active[2]; an_nxt = 6'b111011; end
      3'd3: begin cur_digit = active[3]; an_nxt = 6'b110111; end
      3'd4: begin cur_digit = active[4]; an_nxt = 6'b101111; end
      3'd5: begin cur_digit = active[5]; an_nxt = 6'b011111; end
      default: ;
    endcase
  end

`ifdef LEADING_ZERO_BLANK_EN
  logic [5:0] blank_mask;
  logic       lead;

  // A digit is blank while it and every digit above it are zero; d1 always shows.
  always_comb begin
    blank_mask = '0;
    lead       = 1'b1;
    for (int k = 5; k >= 1; k--) begin
      lead          = lead && (active[k] == 4'd0);
      blank_mask[k] = lead;
    end
  end

  always_comb begin
    cur_blank = 1'b0;
    case (idx)
      3'd1:    cur_blank = blank_mask[1];
      3'd2:    cur_blank = blank_mask[2];
      3'd3:    cur_blank = blank_mask[3];
      3'd4:    cur_blank = blank_mask[4];
      3'd5:    cur_blank = blank_mask[5];
      default: cur_blank = 1'b0;
    endcase
  end
`else
  assign cur_blank = 1'b0;
`endif

  always_ff @(posedge clk) begin
    if (reset) begin
      div        <= '0;
      idx        <= '0;
      active     <= '0;
      shadow     <= '0;
      pending    <= 1'b0;
      frame_done <= 1'b0;
      an         <= 6'b111111;
      seg        <= 7'b1111111;
    end else begin
      div        <= tick ? 16'd0 : div + 16'd1;
      if (tick) begin
        idx <= (idx == 3'd5) ? 3'd0 : idx + 3'd1;
      end
      frame_done <= boundary;
      an         <= an_nxt;
      seg        <= cur_blank ? 7'b1111111 : hex7(cur_digit);

      // The active bank only moves at a frame boundary, so a frame never mixes old and new digits.
      if (boundary) begin
        if (load) begin
          active <= din;
          shadow <= din;
        end else if (pending) begin
          active <= shadow;
        end
        pending <= 1'b0;
      end else if (load) begin
        shadow  <= din;
        pending <= 1'b1;
      end
    end
  end

endmodule

// File: tb/tb_display_scan.sv
// Scoreboard bench for display_scan: a cycle-count reference model predicts outputs per edge.
module tb_display_scan;

  localparam int CPD   = 4;
  localparam int FRAME = 6 * CPD;
  localparam logic [6:0] SEGTAB [16] = '{7'h40, 7'h79, 7'h24, 7'h30, 7'h19, 7'h12, 7'h02, 7'h78,
                                         7'h00, 7'h10, 7'h08, 7'h03, 7'h46, 7'h21, 7'h06, 7'h0E};
  localparam logic [6:0] EXP31 [6] = '{7'h79, 7'h40, 7'h79, 7'h79, 7'h40, 7'h40};

  logic       clk = 1'b0;
  logic       reset;
  logic       load;
  logic [3:0] din [6];
  logic [6:0] seg;
  logic [5:0] an;
  logic       frame_done;
  logic       pending;

  always #5 clk = ~clk;

  display_scan #(.CLKS_PER_DIGIT(CPD)) dut (
    .clk(clk), .reset(reset), .load(load),
    .d1(din[0]), .d2(din[1]), .d3(din[2]), .d4(din[3]), .d5(din[4]), .d6(din[5]),
    .seg(seg), .an(an), .frame_done(frame_done), .pending(pending)
  );

  int          n_checks = 0;
  int          n_pass   = 0;
  logic [14:0] exp_q [$];
  int          m_cyc;
  logic [3:0]  m_active [6];
  logic [3:0]  m_shadow [6];
  logic        m_pending;
  logic        track78   = 1'b0;
  logic        seen78    = 1'b0;
  logic        seen_pend = 1'b0;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    if (obs === exp) n_pass++;
    else $display("FAIL %s: got 0x%0h, expected 0x%0h", tag, obs, exp);
  endtask

  function automatic logic model_blank(input int k);
`ifdef LEADING_ZERO_BLANK_EN
    if (k == 0) return 1'b0;
    for (int j = k; j < 6; j++) if (m_active[j] != 4'd0) return 1'b0;
    return 1'b1;
`else
    return (k < 0);
`endif
  endfunction

  // Predict {seg, an, frame_done, pending} after the coming edge and advance the model.
  task automatic model_step();
    logic [14:0] e;
    int          dig;
    logic        bnd;
    if (reset) begin
      e     = {7'h7F, 6'h3F, 1'b0, 1'b0};
      m_cyc = 0;
      for (int i = 0; i < 6; i++) begin m_active[i] = 4'd0; m_shadow[i] = 4'd0; end
      m_pending = 1'b0;
    end else begin
      dig      = (m_cyc / CPD) % 6;
      bnd      = (m_cyc % FRAME) == FRAME - 1;
      e[14:8]  = model_blank(dig) ? 7'h7F : SEGTAB[m_active[dig]];
      e[7:2]   = ~(6'b000001 << dig);
      e[1]     = bnd;
      if (bnd) begin
        if (load) for (int i = 0; i < 6; i++) begin m_active[i] = din[i]; m_shadow[i] = din[i]; end
        else if (m_pending) for (int i = 0; i < 6; i++) m_active[i] = m_shadow[i];
        m_pending = 1'b0;
      end else if (load) begin
        for (int i = 0; i < 6; i++) m_shadow[i] = din[i];
        m_pending = 1'b1;
      end
      e[0]  = m_pending;
      m_cyc = m_cyc + 1;
    end
    exp_q.push_back(e);
  endtask

  task automatic cycle();
    logic [14:0] e;
    logic [14:0] o;
    model_step();
    @(posedge clk);
    #1;
    o = {seg, an, frame_done, pending};
    e = exp_q.pop_front();
    check($sformatf("out@%0t", $time), 32'(o), 32'(e));
    if (track78 && seg == 7'h78) seen78 = 1'b1;
    if (pending) seen_pend = 1'b1;
  endtask

  task automatic run(input int n);
    for (int i = 0; i < n; i++) cycle();
  endtask

  task automatic run_to(input int p);
    for (int i = 0; i < FRAME && (m_cyc % FRAME) != p; i++) cycle();
  endtask

  task automatic set_d(input logic [3:0] a1, a2, a3, a4, a5, a6);
    din[0] = a1; din[1] = a2; din[2] = a3; din[3] = a4; din[4] = a5; din[5] = a6;
  endtask

  task automatic do_load(input logic [3:0] a1, a2, a3, a4, a5, a6);
    set_d(a1, a2, a3, a4, a5, a6);
    load = 1'b1;
    cycle();
    load = 1'b0;
  endtask

  initial begin
    reset = 1'b1;
    load  = 1'b1;
    set_d(4'hF, 4'hF, 4'hF, 4'hF, 4'hF, 4'hF);
    run(3);
    load = 1'b0;
    check("rst_an",   32'(an), 32'h3F);
    check("rst_seg",  32'(seg), 32'h7F);
    check("rst_fd",   32'(frame_done), 32'h0);
    check("rst_pend", 32'(pending), 32'h0);

    reset = 1'b0;
    cycle();
    check("first_an",  32'(an), 32'h3E);
    check("first_seg", 32'(seg), 32'h40);
    run(3);
    cycle();
    check("second_an", 32'(an), 32'h3D);
    run(60);

    // Mid-frame load waits for the boundary, then shows 1,0,1,1,0,0.
    run_to(5);
    do_load(4'd1, 4'd0, 4'd1, 4'd1, 4'd0, 4'd0);
    check("pend_set", 32'(pending), 32'h1);
    run_to(FRAME - 1);
    check("pend_hold", 32'(pending), 32'h1);
    cycle();
    check("pend_clr", 32'(pending), 32'h0);
    check("fd_pulse", 32'(frame_done), 32'h1);
    for (int k = 0; k < 6; k++) begin
      cycle();
      check($sformatf("frame31_d%0d", k + 1), 32'(seg), 32'(EXP31[k]));
      run(CPD - 1);
    end

    // Two loads in one frame: only the last one may ever reach the display.
    run_to(2);
    do_load(4'd7, 4'd7, 4'd7, 4'd7, 4'd7, 4'd7);
    run(3);
    seen78  = 1'b0;
    track78 = 1'b1;
    do_load(4'd3, 4'd3, 4'd3, 4'd3, 4'd3, 4'd3);
    run_to(FRAME - 1);
    run(2 * FRAME + 1);
    track78 = 1'b0;
    check("no78", 32'(seen78), 32'h0);
    check("seg3", 32'(seg), 32'h30);

    // Load exactly at a boundary goes straight to the active bank.
    run_to(FRAME - 1);
    seen_pend = 1'b0;
    do_load(4'hF, 4'hF, 4'hF, 4'hF, 4'hF, 4'hF);
    check("bnd_pend", 32'(pending), 32'h0);
    cycle();
    check("bnd_segF", 32'(seg), 32'h0E);
    run(FRAME);
    check("bnd_nopend", 32'(seen_pend), 32'h0);

    // Reset mid-frame with data pending discards the shadow bank.
    run_to(8);
    do_load(4'd9, 4'd9, 4'd9, 4'd9, 4'd9, 4'd9);
    check("pre_rst_pend", 32'(pending), 32'h1);
    run(3);
    reset = 1'b1;
    cycle();
    check("mid_rst_an",   32'(an), 32'h3F);
    check("mid_rst_seg",  32'(seg), 32'h7F);
    check("mid_rst_pend", 32'(pending), 32'h0);
    reset = 1'b0;
    run(2 * FRAME + 5);
    check("post_rst_seg",  32'(seg), 32'h40);
    check("post_rst_pend", 32'(pending), 32'h0);

    // Random loads, including ones that land on boundaries.
    for (int i = 0; i < 400; i++) begin
      load = ($urandom_range(0, 11) == 0);
      for (int k = 0; k < 6; k++) din[k] = 4'($urandom_range(0, 15));
      if (i % 97 == 0) run_to(FRAME - 1);
      cycle();
    end
    load = 1'b0;
    run(FRAME);

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule

// File: doc/display_scan.md
DISPLAY_SCAN -- requirements
Module: display_scan

Interface
REQ-001 Parameter CLKS_PER_DIGIT, default 50000, clock cycles each digit stays lit; legal range 2..65535.
REQ-002 clk  input  1  sole clock, all state updates on rising edge.
REQ-003 reset  input  1  synchronous, active-high reset.
REQ-004 load  input  1  one-cycle strobe; capture d1..d6 this cycle.
REQ-005 d1..d6  input  4 each  digit values from the shift/rotate stage; d1 least significant, d6 most significant.
REQ-006 seg  output  7  segment drive {g,f,e,d,c,b,a}, active-low, registered.
REQ-007 an  output  6  digit enables, active-low one-hot, an[k] lights digit d(k+1), registered.
REQ-008 frame_done  output  1  one-cycle pulse at end of each 6-digit frame, registered.
REQ-009 pending  output  1  high while captured data waits for frame boundary, registered.

Function
REQ-010 Prescaler div counts 0..CLKS_PER_DIGIT-1 every cycle and wraps; tick is defined as div==CLKS_PER_DIGIT-1.
REQ-011 Digit index idx (0..5) advances on tick; 5 wraps to 0.
REQ-012 Frame boundary is defined as tick with idx==5.
REQ-013 an and seg reflect idx and the active digit register with exactly 1 cycle latency.
REQ-014 Two register banks: shadow (written by load) and active (displayed); display never reads shadow.
REQ-015 load not coinciding with a boundary: shadow <= d1..d6, pending <= 1 next cycle.
REQ-016 load while pending already high: shadow overwritten, last load wins, pending stays 1.
REQ-017 At a boundary with pending==1 and no load: active <= shadow, pending <= 0.
REQ-018 Load coinciding with a boundary: active <= incoming d1..d6 directly, shadow <= same, pending <= 0.
REQ-019 Active digits change only at frame boundaries; no frame shows mixed old/new digits.
REQ-020 frame_done is 1 in the cycle after each boundary, otherwise 0.
REQ-021 Segment decode, hex 0..F as seg values: 40,79,24,30,19,12,02,78,00,10,08,03,46,21,06,0E (hex).
REQ-022 an is exactly one zero bit at all times after the first cycle out of reset.

Reset
REQ-023 While reset is high: div=0, idx=0, active=0, shadow=0, pending=0, frame_done=0, an=6'b111111, seg=7'b1111111.
REQ-024 reset dominates load; a load in a reset cycle is discarded.
REQ-025 First edge after reset deasserts: an=6'b111110, seg=7'h40 (d1 of zeroed active bank).
REQ-026 Reset mid-frame or with pending==1 discards shadow data and restarts at idx 0.

Configuration
REQ-027 Macro LEADING_ZERO_BLANK_EN: when defined, active digits of value 0 above the most significant nonzero active digit drive seg=7'b1111111 (an still asserted); d1 is never blanked.
REQ-028 Without LEADING_ZERO_BLANK_EN, every digit decodes per REQ-021 including leading zeros.
REQ-029 Macro affects seg only; timing, an, frame_done, pending identical in both builds.

Verification (CLKS_PER_DIGIT=4, frame = 24 cycles)
REQ-030 Reset 3 cycles, release -> an=111110, seg=40 first cycle; an steps 111101,111011,... every 4 cycles; frame_done pulse every 24 cycles.
REQ-031 load mid-frame with d1..d6=1,0,1,1,0,0 -> pending=1 until boundary; next frame digits show seg 79,40,79,79,40,40 (no blank build), pending=0.
REQ-032 Two loads in one frame (first all 7, then all 3) -> only 3s (seg=30) ever displayed; no frame contains 78.
REQ-033 load exactly at boundary with all digits F -> pending never rises; next frame shows seg=0E on all six digits.
REQ-034 LEADING_ZERO_BLANK_EN build, active 0,0,0,1,0,0 (d1..d6) -> d6,d5 blank (7F), d4=79, d3,d2,d1=40; all zeros -> only d1 shows 40.
REQ-035 Assert reset mid-frame with pending=1 -> next cycle outputs per REQ-023, after release display shows zeros, pending=0.
